csa_result_resolver: RTL

- Drain-side partner of the carry-save MAC datapath.
- Accepts one vector per transfer. Each vector holds the redundant (sum, carry) words from the bottom row of all COLS weight-stationary PE columns.
- Resolves each lane to a binary two's-complement result through a 2-stage split carry-propagate pipeline.
- Presents results on a valid/ready stream, marks the last vector of each output tile and pulses tile_done.

---
 rtl/csa_pkg.sv | 15 +
 rtl/csa_cpa_lane.sv | 54 +++++
 rtl/csa_result_resolver.sv | 87 ++++++++
 3 files changed

// File: rtl/csa_pkg.sv
// Shared carry-save accumulator types.
// Imported by the PE array and the result resolver.
package csa_pkg;

  localparam int ACC_WIDTH = 32;
  localparam int ACC_SPLIT = 16;

  typedef logic [ACC_WIDTH-1:0] acc_t;

  typedef struct packed {
    acc_t s;
    acc_t c;
  } cs_pair_t;

endpackage

// File: rtl/csa_cpa_lane.sv
// One lane of the split carry-propagate adder.
// Stage 1 adds the low half, stage 2 the high half plus carry.
module csa_cpa_lane
  import csa_pkg::*;
#(
  parameter int W     = ACC_WIDTH,
  parameter int SPLIT = ACC_SPLIT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld1_i,
  input  logic         ld2_i,
  input  logic [W-1:0] s_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] res_o
);

  localparam int HW = W - SPLIT;

  logic [SPLIT:0]  lo_q;
  logic [HW-1:0]   sh_q;
  logic [HW-1:0]   ch_q;
  logic [W-1:0]    res_q;
  logic [HW-1:0]   cy;
  logic [HW-1:0]   hi;

  assign cy  = {{(HW-1){1'b0}}, lo_q[SPLIT]};
  assign hi  = sh_q + ch_q + cy;
  assign res_o = res_q;

  // Stage 1: low-half add with carry out, keep raw upper halves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= '0;
      sh_q <= '0;
      ch_q <= '0;
    end else if (ld1_i) begin
      lo_q <= {1'b0, s_i[SPLIT-1:0]}
            + {1'b0, c_i[SPLIT-1:0]};
      sh_q <= s_i[W-1:SPLIT];
      ch_q <= c_i[W-1:SPLIT];
    end
  end

  // Stage 2: high-half add folding in the low carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (ld2_i) begin
      res_q <= {hi, lo_q[SPLIT-1:0]};
    end
  end

endmodule

// File: rtl/csa_result_resolver.sv
// Resolves carry-save PE column outputs to binary results
// and frames them into output tiles.
module csa_result_resolver
  import csa_pkg::*;
#(
  parameter int COLS          = 4,
  parameter int WIDTH         = ACC_WIDTH,
  parameter int SPLIT         = ACC_SPLIT,
  parameter int ROWS_PER_TILE = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [COLS*WIDTH-1:0] in_s,
  input  logic [COLS*WIDTH-1:0] in_c,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COLS*WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  tile_done
);

  localparam logic [15:0] LAST_ROW = 16'(ROWS_PER_TILE - 1);

  logic        v1_q;
  logic        v2_q;
  logic [15:0] cnt_q;
  logic        td_q;
  logic        en1;
  logic        en2;
  logic        ld1;
  logic        ld2;
  logic        out_hs;
  logic        last_row;

  assign en2      = !v2_q || out_ready;
  assign en1      = !v1_q || en2;
  assign in_ready = en1 && !clear;
  assign ld1      = in_valid && in_ready;
  assign ld2      = en2 && v1_q;

  assign out_valid = v2_q;
  assign last_row  = (cnt_q == LAST_ROW);
  assign out_last  = v2_q && last_row;
  assign out_hs    = v2_q && out_ready;
  assign tile_done = td_q;

  for (genvar k = 0; k < COLS; k++) begin : g_lane
    csa_cpa_lane #(
      .W     (WIDTH),
      .SPLIT (SPLIT)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ld1_i (ld1),
      .ld2_i (ld2),
      .s_i   (in_s[k*WIDTH +: WIDTH]),
      .c_i   (in_c[k*WIDTH +: WIDTH]),
      .res_o (out_data[k*WIDTH +: WIDTH])
    );
  end

  // Stage valids, tile row counter and tile_done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      cnt_q <= '0;
      td_q  <= 1'b0;
    end else if (clear) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      cnt_q <= '0;
      td_q  <= 1'b0;
    end else begin
      if (en1) v1_q <= in_valid;
      if (en2) v2_q <= v1_q;
      td_q <= out_hs && last_row;
      if (out_hs) begin
        cnt_q <= last_row ? '0 : cnt_q + 16'd1;
      end
    end
  end

endmodule
